// File: rtl/witf_scoreboard.sv
// Write-in-flight scoreboard: circular buffer of pending destination registers with RAW checks.
// Optional flush of youngest entries is compiled in when WITF_FLUSH_EN is defined.
module witf_scoreboard #(
  parameter int DEPTH  = 4,
  parameter int NUM_RS = 2,
  parameter int AW     = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_en,
  input  logic [AW-1:0]        disp_rd,
  input  logic                 wb_en,
  input  logic [NUM_RS*AW-1:0] rs_addr,
  output logic [NUM_RS-1:0]    raw_vec,
  output logic                 isRAW,
  output logic                 witf_full,
  output logic                 witf_empty,
  output logic [CW-1:0]        count,
  output logic                 err
`ifdef WITF_FLUSH_EN
  ,
  input  logic                 flush_en,
  input  logic [CW-1:0]        flush_num
`endif
);

  logic [AW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_cnt_pop;
  logic [CW-1:0]    w_drop;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_off;
  logic [DEPTH-1:0] w_live;

  assign witf_full  = (r_count == CW'(DEPTH));
  assign witf_empty = (r_count == '0);
  assign count      = r_count;
  assign err        = r_err;
  assign isRAW      = |raw_vec;

  // A full buffer still accepts a push when the same cycle retires the oldest entry.
  assign w_pop     = wb_en && !witf_empty;
  assign w_push    = disp_en && (!witf_full || wb_en);
  assign w_cnt_pop = r_count - CW'(w_pop);

`ifdef WITF_FLUSH_EN
  assign w_drop = !flush_en ? '0 : ((flush_num > w_cnt_pop) ? w_cnt_pop : flush_num);
`else
  assign w_drop = '0;
`endif

  // Flushed entries are taken off the young end, so the push lands where they started.
  assign w_wr_idx = r_wr_ptr - PW'(w_drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_idx + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_cnt_pop - w_drop + CW'(w_push);
      if ((disp_en && witf_full && !wb_en) || (wb_en && witf_empty)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= disp_rd;
    end
  end

  // A slot is live when its distance from the oldest entry is below count; x0 never hazards.
  always_comb begin
    w_live = '0;
    w_off  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_off = PW'(j) - r_rd_ptr;
      if ((CW'(w_off) < r_count) && (r_mem[j] != '0)) begin
        w_live[j] = 1'b1;
      end
    end
  end

  always_comb begin
    raw_vec = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_live[j] && (r_mem[j] == rs_addr[i*AW +: AW])) begin
          raw_vec[i] = 1'b1;
        end
      end
    end
  end

endmodule
